fifo_rd_packer: RTL

Read-side consumer of the async FIFO, clocked in the FIFO's read domain. Pops narrow words via the FIFO's `rd`/`empty`/`rd_data` port and accounts for its one-cycle registered read latency. Packs `pack` consecutive words into one wide word presented on a valid/ready output. A flush request emits a partial word with a lane-keep mask.

---
 rtl/fifo_rd_packer_pkg.sv | 22 ++
 rtl/fifo_rd_packer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer_pkg.sv
// Shared definitions for the FIFO read-side packer: state encodings and the
// lane keep-mask helper (also intended for a future write-side unpacker).
package fifo_rd_packer_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_FLUSH_WAIT = 2'd1,
    ST_FLUSH_EMIT = 2'd2
  } state_e;

  localparam int unsigned KEEP_MAX = 32;

  // Mask with the low n bits set; saturates at KEEP_MAX lanes.
  function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned n);
    if (n >= KEEP_MAX) begin
      keep_mask = '1;
    end else begin
      keep_mask = (KEEP_MAX'(1) << n) - KEEP_MAX'(1);
    end
  endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops narrow words from the async FIFO read port (1-cycle read latency) and
// packs `pack` of them, oldest in lane 0, into one wide valid/ready output word.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int data_width = 8,
  parameter int pack       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  output logic                       fifo_rd,
  input  logic [data_width-1:0]      fifo_rd_data,
  input  logic                       flush,
  output logic                       flush_done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [pack*data_width-1:0] out_data,
  output logic [pack-1:0]            out_keep,
  output logic [1:0]                 dbg_state
);

  localparam int CW = $clog2(pack + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(pack);

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      pend_q, pend_d;
  logic [data_width-1:0]     acc_q [pack];
  logic [data_width-1:0]     acc_d [pack];
  logic [pack*data_width-1:0] out_data_q, out_data_d;
  logic [pack-1:0]           out_keep_q, out_keep_d;
  logic                      out_valid_q, out_valid_d;
  logic                      flush_done_q, flush_done_d;

  logic                      out_free;
  logic                      xfer;
  logic                      issue_room;
  logic [CW-1:0]             cnt_base;
  logic [pack*data_width-1:0] full_data;
  logic [pack*data_width-1:0] part_data;

  // Output handshake: a word moves when out_valid && out_ready; while
  // out_valid && !out_ready the output register (data, keep, valid) holds.
  always_comb begin
    out_free   = !out_valid_q || out_ready;
    xfer       = (cnt_q == CNT_FULL) && out_free && (state_q != ST_FLUSH_EMIT);
    issue_room = ({1'b0, cnt_q} + (CW + 1)'(pend_q)) < {1'b0, CNT_FULL};
    // rst gate matters: the FIFO reports not-empty while it is in reset.
    fifo_rd    = !rst && !fifo_empty && (state_q == ST_RUN) && (issue_room || xfer);
    cnt_base   = xfer ? '0 : cnt_q;

    full_data = '0;
    part_data = '0;
    for (int i = 0; i < pack; i++) begin
      full_data[i*data_width +: data_width] = acc_q[i];
      part_data[i*data_width +: data_width] = (CW'(i) < cnt_q) ? acc_q[i] : '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_base;
    pend_d       = fifo_rd;
    acc_d        = acc_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_valid_d  = out_valid_q && !out_ready;
    flush_done_d = 1'b0;

    if (xfer) begin
      out_data_d  = full_data;
      out_keep_d  = '1;
      out_valid_d = 1'b1;
    end

    // The word popped last cycle lands in the next free lane, which restarts
    // at lane 0 when the full word leaves in this same cycle.
    if (pend_q) begin
      for (int i = 0; i < pack; i++) begin
        if (cnt_base == CW'(i)) begin
          acc_d[i] = fifo_rd_data;
        end
      end
      cnt_d = cnt_base + CW'(1);
    end

    case (state_q)
      ST_RUN: begin
        if (flush) begin
          state_d = ST_FLUSH_WAIT;
        end
      end
      ST_FLUSH_WAIT: begin
        if (!pend_q) begin
          if (cnt_base == '0) begin
            flush_done_d = 1'b1;
            state_d      = ST_RUN;
          end else begin
            state_d = ST_FLUSH_EMIT;
          end
        end
      end
      ST_FLUSH_EMIT: begin
        if (out_free) begin
          out_data_d   = part_data;
          out_keep_d   = pack'(keep_mask(32'(cnt_q)));
          out_valid_d  = 1'b1;
          cnt_d        = '0;
          flush_done_d = 1'b1;
          state_d      = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_valid_q  <= 1'b0;
      flush_done_q <= 1'b0;
      for (int i = 0; i < pack; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_valid_q  <= out_valid_d;
      flush_done_q <= flush_done_d;
      for (int i = 0; i < pack; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_keep   = out_keep_q;
  assign out_valid  = out_valid_q;
  assign flush_done = flush_done_q;
  assign dbg_state  = state_q;

endmodule
